me_control: RTL and testbench

Sequencing controller for the full-search motion estimator. It sits directly upstream of the comparator and drives the 16-PE array.
- Steps a 16×16 reference block through 16 candidate rows.
- Staggers the 16 PEs by one cycle each.
- Issues each PE's accumulator-clear strobe and one-hot ready strobe.
- Issues the candidate motion vector for each ready strobe.
- Holds the comparator's start/clear control (CompStart) so the comparator keeps the best result after the search ends.

---
 rtl/me_control.sv | 76 +++++++
 tb/tb_me_control.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/me_control.sv
// Sequencing controller for the full-search motion estimator: steps the
// reference block, staggers the 16 PEs and drives the comparator control.
module me_control (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  AddressR,
  output logic [15:0] NewDist,
  output logic [15:0] PEready,
  output logic [3:0]  VectorX,
  output logic [3:0]  VectorY,
  output logic        CompStart,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [12:0] LAST_COUNT = 13'd4111;

  state_t      state;
  logic [12:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          count <= '0;
        end
        RUN: begin
          // start is deliberately ignored while a search is in flight
          if (count == LAST_COUNT) state <= DONE;
          else                     count <= count + 13'd1;
        end
        DONE: if (start) begin
          state <= RUN;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  logic [13:0] d;

  // PE k runs k cycles behind PE 0; d is its local cycle, negative before it starts.
  always_comb begin
    NewDist = '0;
    PEready = '0;
    VectorX = '0;
    VectorY = '0;
    d       = '0;
    for (int k = 0; k < 16; k++) begin
      d = {1'b0, count} - 14'(k);
      if (state == RUN && !d[13] && d[7:0] == 8'd0) begin
        if (d <= 14'd3840) NewDist[k] = 1'b1;
        if (d >= 14'd256 && d <= 14'd4096) begin
          PEready[k] = 1'b1;
          VectorX    = 4'(k);
          VectorY    = d[11:8] - 4'd1;
        end
      end
    end
  end

  assign AddressR  = (state == RUN && count <= 13'd4095) ? count[7:0] : 8'd0;
  assign CompStart = (state == DONE) || (state == RUN && count != 13'd0);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_me_control.sv
// Scoreboarded random-stimulus bench for me_control.
module tb_me_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  AddressR;
  logic [15:0] NewDist;
  logic [15:0] PEready;
  logic [3:0]  VectorX;
  logic [3:0]  VectorY;
  logic        CompStart;
  logic        done;

  me_control dut (
    .clock(clock), .reset(reset), .start(start),
    .AddressR(AddressR), .NewDist(NewDist), .PEready(PEready),
    .VectorX(VectorX), .VectorY(VectorY), .CompStart(CompStart), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] newd;
    logic [15:0] rdy;
    logic [3:0]  vx;
    logic [3:0]  vy;
    logic        cs;
    logic        dn;
  } out_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pe_cnt[16];
  bit   sim_end = 0;

  // reference model: mode 0=idle 1=run 2=done, mc = search cycle
  int m_mode = 0;
  int m_c = 0;

  function automatic out_t expect_out(int mode, int c);
    out_t o;
    int r, n;
    o = '0;
    if (mode == 2) begin
      o.cs = 1'b1;
      o.dn = 1'b1;
    end else if (mode == 1) begin
      r = c % 256;
      n = c / 256;
      o.addr = (c <= 4095) ? 8'(r) : 8'd0;
      o.cs = (c != 0);
      if (r < 16) begin
        if (n <= 15) o.newd = 16'(1) << r;
        if (n >= 1 && n <= 16) begin
          o.rdy = 16'(1) << r;
          o.vx  = 4'(r);
          o.vy  = 4'(n - 1);
        end
      end
    end
    return o;
  endfunction

  // drive inputs for the next edge and queue the response that edge must produce
  task automatic step(input bit r, input bit s);
    reset = r;
    start = s;
    if (r) begin
      m_mode = 0; m_c = 0;
    end else if (m_mode == 0 || m_mode == 2) begin
      if (s) begin m_mode = 1; m_c = 0; end
    end else begin
      if (m_c == 4111) m_mode = 2;
      else m_c++;
    end
    exp_q.push_back(expect_out(m_mode, m_c));
    @(posedge clock);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // monitor: every cycle the DUT presents a full output vector
  always @(negedge clock) begin
    out_t got, want;
    if (!sim_end && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = '{AddressR, NewDist, PEready, VectorX, VectorY, CompStart, done};
      cyc++;
      total++;
      if (got !== want) begin
        bad++;
        if (bad <= 20)
          $display("FAIL outputs cyc=%0d got a=%h nd=%h rdy=%h vx=%0d vy=%0d cs=%b dn=%b exp a=%h nd=%h rdy=%h vx=%0d vy=%0d cs=%b dn=%b",
                   cyc, got.addr, got.newd, got.rdy, got.vx, got.vy, got.cs, got.dn,
                   want.addr, want.newd, want.rdy, want.vx, want.vy, want.cs, want.dn);
      end
      for (int k = 0; k < 16; k++) if (PEready[k] === 1'b1) pe_cnt[k]++;
    end
  end

  initial begin
    int sum;
    for (int k = 0; k < 16; k++) pe_cnt[k] = 0;
    // first queued response is for the reset edge
    exp_q.push_back(expect_out(0, 0));
    @(posedge clock);
    #1;
    step(1, 0);
    for (int i = 0; i < 5; i++) step(0, 0);

    // run 1: random start noise during RUN, forced start at c=1000
    for (int k = 0; k < 16; k++) pe_cnt[k] = 0;
    step(0, 1);
    while (m_mode == 1)
      step(0, (m_c == 999) || ($urandom_range(0, 7) == 0));
    step(0, 0);
    step(0, 0);
    sum = 0;
    for (int k = 0; k < 16; k++) begin
      check_int($sformatf("pe%0d_ready_pulses", k), pe_cnt[k], 16);
      sum += pe_cnt[k];
    end
    check_int("total_ready_pulses", sum, 256);

    // linger in DONE a random while, then restart; run 2 to completion
    for (int i = 0, n = $urandom_range(1, 6); i < n; i++) step(0, 0);
    step(0, 1);
    while (m_mode == 1) step(0, $urandom_range(0, 3) == 0);
    step(0, 0);

    // run 3: reset mid-search at c=2000, then stay idle
    step(0, 1);
    while (m_c < 2000) step(0, $urandom_range(0, 7) == 0);
    step(1, 0);
    for (int i = 0; i < 20; i++) step(0, 0);

    // random short bursts of start/reset from idle
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    step(1, 0);
    step(0, 0);

    @(negedge clock);
    #1;
    sim_end = 1;
    check_int("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
